// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding and
// default operand / counter widths.
package mult_pkg;

  localparam int MULT_WIDTH = 8;
  localparam int MULT_CNT_W = 3;

  // Encoding 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add_rc.sv
// WIDTH-bit ripple-carry adder formed by chaining 1-bit full adders.
module add_rc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned WIDTH x WIDTH shift-add multiplier around one ripple adder.
// Define MULT_ABORT_EN to add an 'abort' input that cancels a running multiply.
module shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef MULT_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     phi_q, phi_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic [WIDTH-1:0]     addB;
  logic [WIDTH-1:0]     addSum;
  logic                 addCout;
  logic [2*WIDTH-1:0]   shiftNext;
  logic                 abortReq;

`ifdef MULT_ABORT_EN
  assign abortReq = abort;
`else
  assign abortReq = 1'b0;
`endif

  assign addB = q_q[0] ? m_q : '0;

  add_rc #(.WIDTH(WIDTH)) u_add (
    .a    (phi_q),
    .b    (addB),
    .cin  (1'b0),
    .sum  (addSum),
    .cout (addCout)
  );

  // Carry-out becomes the new MSB so the full 2W-bit product is kept.
  assign shiftNext = {addCout, addSum, q_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (abortReq)             state_d = ST_IDLE;
        else if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    m_d    = m_q;
    phi_d  = phi_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    prod_d = prod_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d   = a;
          q_d   = b;
          phi_d = '0;
          cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (abortReq) begin
          m_d   = '0;
          phi_d = '0;
          q_d   = '0;
          cnt_d = '0;
        end else begin
          {phi_d, q_d} = shiftNext;
          cnt_d        = cnt_q + 1'b1;
          // Final iteration: publish the product and park the counter at zero.
          if (cnt_q == CNT_LAST) begin
            prod_d = shiftNext;
            cnt_d  = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    <= '0;
      phi_q  <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      m_q    <= m_d;
      phi_q  <= phi_d;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
    end
  end

  assign product = prod_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl: stimulus pushes expected products,
// a negedge monitor pops and compares them whenever done is seen.
module tb_shift_add_mult_ctrl;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
`ifdef MULT_ABORT_EN
  logic               abort;
`endif
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int checks = 0;
  int errors = 0;
  logic [2*WIDTH-1:0] expQ[$];
  logic prevDone = 1'b0;

  shift_add_mult_ctrl #(.WIDTH(WIDTH), .CNT_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
`ifdef MULT_ABORT_EN
    .abort   (abort),
`endif
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedDone: got product %0d, expected no done", product);
      end else begin
        checkOutput("product", 32'(product), 32'(expQ.pop_front()));
      end
      checkOutput("donePulse", 32'(prevDone), 32'd0);
    end
    prevDone = rst_n && done;
  end

  task automatic waitDone(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    if (!done) checkOutput("doneTimeout", 32'(done), 32'd1);
  endtask

  // Called at a negedge while idle; start is held for the whole operation.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic [2*WIDTH-1:0] exp);
    int n;
    a = av;
    b = bv;
    start = 1'b1;
    expQ.push_back(exp);
    waitDone(n);
    start = 1'b0;
    checkOutput("latency", 32'(n), 32'(WIDTH + 1));
    checkOutput("busyAtDone", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("busyAfter", 32'(busy), 32'd0);
    checkOutput("productHeld", 32'(product), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
`ifdef MULT_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetProduct", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(8'd13, 8'd11, 16'd143);
    applyStimulus(8'd255, 8'd255, 16'd65025);
    applyStimulus(8'd0, 8'd200, 16'd0);

    // Second request presented while busy must be ignored until idle.
    a = 8'd3;
    b = 8'd5;
    start = 1'b1;
    expQ.push_back(16'd15);
    @(negedge clk);
    a = 8'd7;
    b = 8'd7;
    waitDone(n);
    checkOutput("latencyBusyStart", 32'(n), 32'(WIDTH));
    expQ.push_back(16'd49);
    @(negedge clk);
    checkOutput("idleBetween", 32'(busy), 32'd0);
    waitDone(n);
    start = 1'b0;
    checkOutput("latencySecond", 32'(n), 32'(WIDTH + 1));
    @(negedge clk);

    // Asynchronous reset in the middle of a multiply.
    a = 8'd100;
    b = 8'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("busyBeforeReset", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncBusy", 32'(busy), 32'd0);
    checkOutput("asyncDone", 32'(done), 32'd0);
    checkOutput("asyncProduct", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'd2, 8'd9, 16'd18);

    // Start held continuously: one result every WIDTH+2 cycles.
    a = 8'd6;
    b = 8'd7;
    start = 1'b1;
    repeat (3) expQ.push_back(16'd42);
    waitDone(n);
    checkOutput("b2bFirst", 32'(n), 32'(WIDTH + 1));
    waitDone(n);
    checkOutput("b2bPeriod", 32'(n), 32'(WIDTH + 2));
    repeat (5) @(negedge clk);
    checkOutput("b2bStable", 32'(product), 32'd42);
    waitDone(n);
    start = 1'b0;
    checkOutput("b2bPeriod2", 32'(n + 5), 32'(WIDTH + 2));
    @(negedge clk);
    checkOutput("b2bIdle", 32'(busy), 32'd0);

`ifdef MULT_ABORT_EN
    applyStimulus(8'd13, 8'd11, 16'd143);
    a = 8'd9;
    b = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortProduct", 32'(product), 32'd143);
    repeat (2) @(negedge clk);
    applyStimulus(8'd9, 8'd9, 16'd81);
`endif

    repeat (2) @(negedge clk);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
- Sequential unsigned W×W multiplier controller built around a single W-bit ripple-carry adder.
- Latches the operands, then performs one conditional add and one right-shift per cycle for W cycles.
- Handshakes the 2W-bit product back to the requester.
- Sits between a requester (register file / test harness) and the shared ripple adder datapath.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.
- CNT_W, 3, iteration counter width; must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  multiplicand, sampled with start
- b  input  WIDTH  multiplier, sampled with start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; product valid
- product  output  2*WIDTH  result; held until next accepted start

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (asserted asynchronously, at any time including mid-operation):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal M, P_hi, Q and count cleared to 0.
  - No partial result survives reset.
- States: IDLE=0, RUN=1, DONE=2; encoding 3 is illegal and goes to IDLE on the next edge.
- IDLE, start=1 at edge E0:
  - M<=a, Q<=b, P_hi<=0, count<=0; state->RUN.
  - start=0 keeps IDLE.
- RUN, each edge E1..EW:
  - {c, s} = P_hi + (Q[0] ? M : 0), computed by the adder sub-module with cin=0; c is the carry-out.
  - {P_hi, Q} <= {c, s, Q[W-1:1]} (logical right shift through the carry).
  - count<=count+1.
  - When count==WIDTH-1 at the edge, state->DONE.
- Latency:
  - RUN lasts exactly WIDTH cycles, independent of operand values.
  - done=1 in the cycle after E_WIDTH (9 cycles after E0 for WIDTH=8).
- DONE:
  - done=1 for one cycle; product={P_hi, Q}; state->IDLE at the next edge.
- Product register:
  - product is registered; it updates only on DONE entry and holds through IDLE.
  - A new start clears it only when the next DONE is entered.
- start while busy (RUN or DONE): ignored; no queuing. start is accepted again only on the first IDLE edge.
- Operand stability: a and b may change freely after E0; only the latched copies are used.
- Width rule: carry-out c is never lost, so the product is exact for all inputs (max (2^W−1)^2 fits in 2W bits).
- Counter wrap: count must not wrap within RUN; it is cleared on acceptance.

Optional Feature:
- Macro: MULT_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 at any edge while in RUN: state->IDLE, busy->0, no done pulse; product keeps its previous value; internal registers cleared.
  - abort is ignored in IDLE and DONE.
  - abort and start in the same IDLE edge: start wins.
- Undefined: abort port does not exist; behaviour as above.

Decomposition:
- Shared package mult_pkg:
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE (2-bit).
  - default WIDTH and CNT_W constants.
- One sub-module, add_rc: WIDTH-bit ripple-carry adder built from chained 1-bit full adders.
  - Ports a, b, cin, sum, cout; instantiated once with cin tied to 0.
- FSM, counter and shift register stay in the top module.

Test Plan:
- Basic multiply: a=13, b=11, start pulse -> done exactly 9 cycles after the start edge; product=143 (0x008F); busy high for 9 cycles.
- Max operands: a=255, b=255 -> product=65025 (0xFE01), proving the carry-out is captured; a=0, b=200 -> product=0, same latency.
- Start during busy: a=3, b=5, then start with a=7, b=7 held during RUN and the DONE cycle -> single done, product=15; second request accepted only once idle again -> product=49.
- Async reset: rst_n low mid-RUN (cycle 4) -> busy, done and product drop to 0 immediately without a clock edge; after release, a=2, b=9 -> product=18.
- Back-to-back: start held high continuously with a=6, b=7 -> done every 10 cycles; product=42 each time; product stable between pulses.
- MULT_ABORT_EN build: prior product=143; start a=9, b=9, abort at RUN cycle 3 -> no done, busy low next cycle, product stays 143; the following request completes normally.
